// File: rtl/wavetable_loader_if.sv
// Host byte stream and wavetable RAM write port of the wavetable loader.
// The host/bench drives through master; the loader implements slave.
interface wavetable_loader_if;
  logic       InValid;
  logic [7:0] InData;
  logic       InReady;
  logic       Abort;
  logic       WE;
  logic [7:0] Address;
  logic [5:0] Data;
  logic       Busy;
  logic       Done;
  logic       Error;

  modport master (
    output InValid, InData, Abort,
    input  InReady, WE, Address, Data, Busy, Done, Error
  );

  modport slave (
    input  InValid, InData, Abort,
    output InReady, WE, Address, Data, Busy, Done, Error
  );
endinterface

// File: rtl/wavetable_loader.sv
// Wavetable loader: decodes framed host bytes (header, count, samples) into
// single-cycle writes on the four-bank wavetable RAM write port.
module wavetable_loader (
  input  logic         CLK,
  input  logic         RST,
  wavetable_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COUNT, DATA, DONE} state_t;

  state_t     state;
  logic [1:0] bank;
  logic [5:0] ptr;
  logic [6:0] remaining;
  logic       accept;

  // Ready drops for the DONE cycle, while aborting and during reset.
  assign bus.InReady = ~RST & ~bus.Abort & (state != DONE);
  assign accept      = bus.InValid & bus.InReady;

  // Frame FSM with registered RAM write port and status pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      bank        <= 2'd0;
      ptr         <= 6'd0;
      remaining   <= 7'd0;
      bus.WE      <= 1'b0;
      bus.Address <= 8'd0;
      bus.Data    <= 6'd0;
      bus.Busy    <= 1'b0;
      bus.Done    <= 1'b0;
      bus.Error   <= 1'b0;
    end else begin
      bus.WE    <= 1'b0;
      bus.Done  <= 1'b0;
      bus.Error <= 1'b0;
      if (bus.Abort) begin
        state    <= IDLE;
        bus.Busy <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              bank     <= bus.InData[7:6];
              ptr      <= bus.InData[5:0];
              state    <= COUNT;
              bus.Busy <= 1'b1;
            end
          end
          COUNT: begin
            if (accept) begin
              if (bus.InData[7:6] != 2'b00) begin
                // Rejected frame: back to IDLE so the next header is accepted at once.
                state     <= IDLE;
                bus.Busy  <= 1'b0;
                bus.Error <= 1'b1;
              end else begin
                remaining <= {1'b0, bus.InData[5:0]} + 7'd1;
                state     <= DATA;
              end
            end
          end
          DATA: begin
            if (accept) begin
              bus.WE      <= 1'b1;
              bus.Address <= {bank, ptr};
              bus.Data    <= bus.InData[5:0];
              // 6-bit pointer wraps inside the bank, never carrying into it.
              ptr         <= ptr + 6'd1;
              remaining   <= remaining - 7'd1;
              if (remaining == 7'd1) begin
                state    <= DONE;
                bus.Done <= 1'b1;
              end
            end
          end
          DONE: begin
            state    <= IDLE;
            bus.Busy <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            bus.Busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wavetable_loader.sv
// Self-checking bench for wavetable_loader: cycle vector table, directed
// wrap/throttle sequences and randomized frames against a frame-level model.
module tb_wavetable_loader;

  logic CLK;
  logic RST;
  wavetable_loader_if bus ();

  wavetable_loader dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Write monitor: records every RAM write and pulse counts.
  logic [13:0] obs[$];
  int mon_done = 0;
  int mon_err  = 0;
  int mon_bad  = 0;
  always @(posedge CLK) begin
    #1;
    if (bus.WE === 1'b1) obs.push_back({bus.Address, bus.Data});
    if (bus.Done === 1'b1) begin
      mon_done++;
      if (bus.WE !== 1'b1) mon_bad++;
    end
    if (bus.Error === 1'b1) begin
      mon_err++;
      if (bus.WE === 1'b1) mon_bad++;
    end
  end

  typedef struct {
    logic       rst, abort, valid;
    logic [7:0] din;
    logic       rdy, we;
    logic [7:0] addr;
    logic [5:0] dat;
    logic       busy, done, err;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic r, input logic ab, input logic v, input logic [7:0] d,
                     input logic rdy, input logic we, input logic [7:0] a,
                     input logic [5:0] dt, input logic b, input logic dn, input logic e);
    vec_t x;
    x.rst = r; x.abort = ab; x.valid = v; x.din = d;
    x.rdy = rdy; x.we = we; x.addr = a; x.dat = dt;
    x.busy = b; x.done = dn; x.err = e;
    vecs.push_back(x);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int tries;
    tries = 0;
    @(negedge CLK);
    bus.InValid = 1'b1;
    bus.InData  = b;
    #1;
    while (bus.InReady !== 1'b1 && tries < 20) begin
      @(negedge CLK);
      #1;
      tries++;
    end
    if (bus.InReady !== 1'b1) chk("ready_timeout", {31'd0, bus.InReady}, 32'd1);
    @(posedge CLK);
    #1;
    bus.InValid = 1'b0;
    bus.InData  = 8'($urandom);
  endtask

  task automatic gap();
    @(negedge CLK);
    bus.InValid = 1'b0;
    bus.InData  = 8'($urandom);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, dbase, ebase, bbase;
    logic [13:0] expw[$];
    int exp_done, exp_err;

    RST = 1'b1;
    bus.Abort   = 1'b0;
    bus.InValid = 1'b0;
    bus.InData  = 8'h00;
    repeat (2) @(posedge CLK);

    // rst ab v  din    rdy we addr   dat  busy done err
    add(1, 0, 0, 8'h00,  0, 0, 8'h00, 6'h00, 0, 0, 0);
    add(0, 0, 1, 8'h45,  1, 0, 8'h00, 6'h00, 1, 0, 0);
    add(0, 0, 1, 8'h02,  1, 0, 8'h00, 6'h00, 1, 0, 0);
    add(0, 0, 1, 8'h11,  1, 1, 8'h45, 6'h11, 1, 0, 0);
    add(0, 0, 1, 8'h22,  1, 1, 8'h46, 6'h22, 1, 0, 0);
    add(0, 0, 1, 8'h3F,  1, 1, 8'h47, 6'h3F, 1, 1, 0);
    add(0, 0, 1, 8'h99,  0, 0, 8'h47, 6'h3F, 0, 0, 0);
    add(0, 0, 1, 8'h00,  1, 0, 8'h47, 6'h3F, 1, 0, 0);
    add(0, 0, 1, 8'h80,  1, 0, 8'h47, 6'h3F, 0, 0, 1);
    add(0, 0, 1, 8'h10,  1, 0, 8'h47, 6'h3F, 1, 0, 0);
    add(0, 0, 1, 8'h00,  1, 0, 8'h47, 6'h3F, 1, 0, 0);
    add(0, 0, 1, 8'h05,  1, 1, 8'h10, 6'h05, 1, 1, 0);
    add(0, 0, 0, 8'h00,  0, 0, 8'h10, 6'h05, 0, 0, 0);
    add(0, 0, 1, 8'h20,  1, 0, 8'h10, 6'h05, 1, 0, 0);
    add(0, 0, 1, 8'h04,  1, 0, 8'h10, 6'h05, 1, 0, 0);
    add(0, 0, 1, 8'h01,  1, 1, 8'h20, 6'h01, 1, 0, 0);
    add(0, 0, 1, 8'h02,  1, 1, 8'h21, 6'h02, 1, 0, 0);
    add(0, 1, 1, 8'h03,  0, 0, 8'h21, 6'h02, 0, 0, 0);
    add(0, 0, 0, 8'h03,  1, 0, 8'h21, 6'h02, 0, 0, 0);
    add(0, 0, 1, 8'h40,  1, 0, 8'h21, 6'h02, 1, 0, 0);
    add(0, 0, 1, 8'h04,  1, 0, 8'h21, 6'h02, 1, 0, 0);
    add(0, 0, 1, 8'h07,  1, 1, 8'h40, 6'h07, 1, 0, 0);
    add(0, 0, 1, 8'h08,  1, 1, 8'h41, 6'h08, 1, 0, 0);
    add(1, 0, 1, 8'h09,  0, 0, 8'h00, 6'h00, 0, 0, 0);
    add(0, 0, 1, 8'h7F,  1, 0, 8'h00, 6'h00, 1, 0, 0);
    add(0, 0, 1, 8'h01,  1, 0, 8'h00, 6'h00, 1, 0, 0);
    add(0, 0, 1, 8'h2A,  1, 1, 8'h7F, 6'h2A, 1, 0, 0);
    add(0, 0, 1, 8'hFF,  1, 1, 8'h40, 6'h3F, 1, 1, 0);
    add(0, 0, 0, 8'h00,  0, 0, 8'h40, 6'h3F, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      RST         = vecs[i].rst;
      bus.Abort   = vecs[i].abort;
      bus.InValid = vecs[i].valid;
      bus.InData  = vecs[i].din;
      #1;
      chk($sformatf("vec%0d_ready", i), {31'd0, bus.InReady}, {31'd0, vecs[i].rdy});
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d_outs", i),
          {14'd0, bus.WE, bus.Address, bus.Data, bus.Busy, bus.Done, bus.Error},
          {14'd0, vecs[i].we, vecs[i].addr, vecs[i].dat, vecs[i].busy, vecs[i].done, vecs[i].err});
    end
    @(negedge CLK);
    bus.InValid = 1'b0;

    // Throttled frame: each write lands one cycle after its accept, no repeats.
    base = obs.size();
    send_byte(8'h80); gap();
    send_byte(8'h01); gap();
    send_byte(8'h2A);
    chk("thr_w0", {18'd0, bus.WE, bus.Address, bus.Data}, {18'd0, 1'b1, 8'h80, 6'h2A});
    gap();
    chk("thr_nodup", {31'd0, bus.WE}, 32'd0);
    send_byte(8'h15);
    chk("thr_w1", {18'd0, bus.WE, bus.Address, bus.Data, bus.Done}, {17'd0, 1'b1, 8'h81, 6'h15, 1'b1});
    repeat (3) gap();
    chk("thr_count", obs.size() - base, 2);

    // Full bank starting at offset 62 of bank 3.
    base  = obs.size();
    dbase = mon_done;
    send_byte(8'hFE);
    send_byte(8'h3F);
    for (int i = 0; i < 64; i++) send_byte(8'(i) & 8'h3F);
    repeat (3) gap();
    chk("full_count", obs.size() - base, 64);
    chk("full_done", mon_done - dbase, 1);
    for (int i = 0; i < 64 && base + i < obs.size(); i++) begin
      logic [7:0] ea;
      ea = 8'hC0 | 8'((62 + i) % 64);
      chk($sformatf("full_w%0d", i), {18'd0, obs[base+i]}, {18'd0, ea, 6'(i)});
    end

    // Randomized frames against a frame-level model.
    base  = obs.size();
    dbase = mon_done;
    ebase = mon_err;
    bbase = mon_bad;
    exp_done = 0;
    exp_err  = 0;
    for (int f = 0; f < 30; f++) begin
      logic [1:0] bk;
      logic [5:0] off;
      int n;
      logic bad;
      bk  = 2'($urandom);
      off = 6'($urandom);
      n   = $urandom_range(1, 20);
      if (f % 5 == 0) n = $urandom_range(50, 64);
      bad = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) gap();
      send_byte({bk, off});
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) gap();
      if (bad) begin
        send_byte({2'($urandom_range(1, 3)), 6'($urandom)});
        exp_err++;
      end else begin
        send_byte({2'b00, 6'(n - 1)});
        for (int i = 0; i < n; i++) begin
          logic [7:0] s;
          s = 8'($urandom);
          if ($urandom_range(0, 3) == 0) gap();
          send_byte(s);
          expw.push_back({bk, 6'((off + i) % 64), s[5:0]});
        end
        exp_done++;
      end
    end
    repeat (3) gap();
    chk("rnd_count", obs.size() - base, expw.size());
    chk("rnd_done", mon_done - dbase, exp_done);
    chk("rnd_err", mon_err - ebase, exp_err);
    chk("rnd_pulse_align", mon_bad - bbase, 0);
    begin
      int mism;
      mism = 0;
      for (int i = 0; i < expw.size() && base + i < obs.size(); i++)
        if (obs[base+i] !== expw[i]) begin
          mism++;
          if (mism <= 5)
            $display("FAIL rnd_w%0d actual=0x%0h required=0x%0h", i, obs[base+i], expw[i]);
        end
      checks++;
      if (mism != 0) failures++;
    end
    chk("end_idle", {31'd0, bus.Busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wavetable_loader.md
# wavetable_loader

Host-side writer for the four-bank wavetable RAM. It accepts a framed byte stream from the host interface over a valid/ready handshake and decodes each frame into a burst of single-cycle sample writes on the RAM write port (`WE`, `Address[7:0]`, `Data[5:0]`). It sits between the host command decoder and the wavetable RAM, and is the only agent that drives the RAM write port.

## Interface
- No parameters. Bank count (4), bank depth (64) and sample width (6) are fixed by the wavetable RAM.
- `CLK` input 1: system clock; all state changes on the rising edge.
- `RST` input 1: synchronous, active-high reset.
- `Abort` input 1: synchronous frame abort; priority below `RST`.
- `InValid` input 1: host byte valid.
- `InData` input 8: host byte.
- `InReady` output 1: loader can accept a byte. Combinational: `~RST & ~Abort & (state != DONE)`.
- `WE` output 1: RAM write enable, registered.
- `Address` output 8: RAM address `{bank[1:0], offset[5:0]}`, registered.
- `Data` output 6: sample to write, registered.
- `Busy` output 1: high whenever state != IDLE, registered.
- `Done` output 1: one-cycle pulse when a frame completes.
- `Error` output 1: one-cycle pulse when a frame is rejected.

## Operation
- A byte is accepted on a rising edge when `InValid & InReady` is high. `InData` is ignored when no byte is accepted.
- Frame format:
  - Byte 0 is the header: `[7:6]` = bank, `[5:0]` = start offset.
  - Byte 1 is the count: `[7:6]` must be 0; `[5:0]` = N−1, so N is 1..64.
  - Bytes 2..N+1 are samples. Bits `[5:0]` are written; bits `[7:6]` are ignored.
- State machine: IDLE, COUNT, DATA, DONE.
  - IDLE: on accept, latch bank and pointer from the header, then go to COUNT.
  - COUNT: on accept with `InData[7:6] != 0`, go to IDLE and raise `Error` for the next cycle. With `InData[7:6] == 0`, load the 7-bit remaining count with `InData[5:0] + 1`, then go to DATA.
  - DATA: on accept, register `WE=1`, `Address={bank, ptr}`, `Data=InData[5:0]`. Then increment `ptr` modulo 64 and decrement remaining. If remaining was 1, go to DONE; otherwise stay in DATA.
  - DONE: `InReady=0` for one cycle, `Done=1`, then go to IDLE unconditionally.
- Pointer wrap: writes wrap within the selected bank. Offset 62 with N=4 writes offsets 62, 63, 0, 1 of the same bank. A write never crosses into another bank.
- `WE` is 0 in every cycle that does not immediately follow a DATA-state accept.
- `Address` and `Data` hold their last values when `WE` is 0.
- Abort: from any state, go to IDLE on the next edge. `Busy`, `WE` and `Done` are 0 the following cycle, and `Error` is not raised. Because `InReady` is low while `Abort` is high, an abort never coincides with an accept.
- Reset: state IDLE, `WE=0`, `Address=0`, `Data=0`, `Busy=0`, `Done=0`, `Error=0`. Internal bank, pointer and count are cleared. `InReady=0` while `RST` is high. Reset in mid-frame discards the frame with no further writes; writes already issued stand.

## Timing
- Write latency is 1 cycle: a sample accepted at edge k gives `WE=1` during cycle k..k+1.
- Sustained throughput is one sample per clock while `InValid` is held high.
- Frame length is N+2 accepted bytes plus 1 DONE cycle, so the minimum frame-to-frame spacing is N+3 cycles.
- The final sample's `WE` pulse and the `Done` pulse occur in the same cycle.
- `Error` asserts in the cycle after the bad count byte is accepted. The loader is back in IDLE in that same cycle, so it can accept a new header immediately.
- `Busy` goes high the cycle after the header is accepted and goes low the cycle after DONE or abort.
- `InValid` low in any state inserts wait cycles with no state change and no write.

## Test plan
- Nominal burst:
  - Stimulus: bytes 0x45, 0x02, 0x11, 0x22, 0x3F sent back-to-back.
  - Response: three consecutive `WE` cycles with Address 0x45/0x46/0x47 and Data 0x11/0x22/0x3F. `Done` is high with the third write. `InReady` is low for one cycle, and `Busy` falls next.
- Wrap and full bank:
  - Stimulus: header 0xFE, count 0x3F, then 64 samples with values i & 0x3F.
  - Response: addresses 0xFE, 0xFF, 0xC0 … 0xFD. No address outside 0xC0–0xFF. Exactly 64 `WE` pulses.
- Bad count:
  - Stimulus: header 0x00, then count 0x80.
  - Response: no `WE`, `Error` pulses once, state is IDLE. A following frame 0x10, 0x00, 0x05 writes Address 0x10 with Data 0x05.
- Throttled input:
  - Stimulus: frame 0x80, 0x01, 0x2A, 0x15 with `InValid` toggled every other cycle.
  - Response: two writes (0x80←0x2A, 0x81←0x15), each one cycle after its accept. No duplicate writes.
- Abort and reset mid-frame:
  - Stimulus: `Abort` after 2 of 5 samples.
  - Response: only 2 `WE` pulses, no `Done`, no `Error`, `Busy` low after 1 cycle.
  - Stimulus: repeat with `RST` instead of `Abort`.
  - Response: all outputs are 0 and the next frame decodes normally.
